// File: rtl/board_io_bridge.sv
// Board-level I/O conditioning: switch synchronise/debounce, gpio/interrupt split,
// LED pulse stretching and a stretched core reset, all in one clock domain.
module board_io_bridge #(
  parameter int N_SW               = 8,
  parameter int N_GPIO_IN          = 4,
  parameter int N_INT              = 4,
  parameter int N_LED              = 8,
  parameter int DEBOUNCE_CYCLES    = 16,
  parameter int INT_MODE           = 0,
  parameter int LED_STRETCH_CYCLES = 0,
  parameter int RESET_HOLD_CYCLES  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_SW-1:0]      switch,
  output logic [N_SW-1:0]      sw_state,
  output logic [N_GPIO_IN-1:0] gpio_in,
  output logic [N_INT-1:0]     int_exts,
  input  logic [N_LED-1:0]     led_core,
  output logic [N_LED-1:0]     led,
  output logic                 core_reset
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int LS_W = (LED_STRETCH_CYCLES > 0) ? $clog2(LED_STRETCH_CYCLES + 1) : 1;
  localparam int RH_W = (RESET_HOLD_CYCLES > 0) ? $clog2(RESET_HOLD_CYCLES + 1) : 1;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LS_W-1:0] LS_LOAD = LS_W'(LED_STRETCH_CYCLES);
  localparam logic [RH_W-1:0] RH_LOAD = RH_W'(RESET_HOLD_CYCLES);

  logic [N_SW-1:0]  s1_q, s2_q;
  logic [N_SW-1:0]  sw_q, sw_d;
  logic [DB_W-1:0]  db_cnt_q [N_SW];
  logic [DB_W-1:0]  db_cnt_d [N_SW];

  logic [N_INT-1:0] int_src;
  logic [N_INT-1:0] int_q, int_d;
  logic [N_INT-1:0] int_prev_q;

  logic [N_LED-1:0] led_q, led_d;
  logic [LS_W-1:0]  ls_cnt_q [N_LED];
  logic [LS_W-1:0]  ls_cnt_d [N_LED];

  logic [RH_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic             core_rst_q, core_rst_d;

  // A bit changes only once s2 has differed from the accepted state for
  // DEBOUNCE_CYCLES consecutive edges; any agreeing edge restarts the count.
  always_comb begin
    sw_d = sw_q;
    for (int i = 0; i < N_SW; i++) begin
      db_cnt_d[i] = '0;
      if (s2_q[i] != sw_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          sw_d[i] = s2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign int_src = sw_q[N_GPIO_IN +: N_INT];

  // The previous-value register tracks even while held in reset, so a source
  // that is already high when interrupts are enabled does not fire a pulse.
  always_comb begin
    int_d = '0;
    if (!core_rst_q) begin
      int_d = (INT_MODE == 1) ? (int_src & ~int_prev_q) : int_src;
    end
  end

  always_comb begin
    for (int i = 0; i < N_LED; i++) begin
      led_d[i] = led_core[i] | (ls_cnt_q[i] != '0);
      if (led_core[i]) begin
        ls_cnt_d[i] = LS_LOAD;
      end else if (ls_cnt_q[i] != '0) begin
        ls_cnt_d[i] = ls_cnt_q[i] - 1'b1;
      end else begin
        ls_cnt_d[i] = '0;
      end
    end
  end

  always_comb begin
    rst_cnt_d  = rst_cnt_q;
    core_rst_d = core_rst_q;
    if (rst_cnt_q != '0) begin
      rst_cnt_d = rst_cnt_q - 1'b1;
    end else begin
      core_rst_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q       <= '0;
      s2_q       <= '0;
      sw_q       <= '0;
      int_q      <= '0;
      int_prev_q <= '0;
      led_q      <= '0;
      rst_cnt_q  <= RH_LOAD;
      core_rst_q <= 1'b1;
      for (int i = 0; i < N_SW; i++) begin
        db_cnt_q[i] <= '0;
      end
      for (int i = 0; i < N_LED; i++) begin
        ls_cnt_q[i] <= '0;
      end
    end else begin
      s1_q       <= switch;
      s2_q       <= s1_q;
      sw_q       <= sw_d;
      int_q      <= int_d;
      int_prev_q <= int_src;
      led_q      <= led_d;
      rst_cnt_q  <= rst_cnt_d;
      core_rst_q <= core_rst_d;
      for (int i = 0; i < N_SW; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
      for (int i = 0; i < N_LED; i++) begin
        ls_cnt_q[i] <= ls_cnt_d[i];
      end
    end
  end

  assign sw_state   = sw_q;
  assign gpio_in    = sw_q[N_GPIO_IN-1:0];
  assign int_exts   = int_q;
  assign led        = led_q;
  assign core_reset = core_rst_q;

endmodule
